// File: rtl/dio_bank.sv
// dio_bank: debounced key/switch entry register with a multi-digit seven-segment readout.
// Each of the three keys is synchronised, debounced and turned into a one-cycle command
// pulse on a rising debounced level. Commands are clear, load and increment, executed in
// that priority. Load writes the switch byte into the current byte lane and advances the lane.
// Every hex digit shows one nibble of the register, active-low gfedcba.
module dio_bank #(
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 50000,
    localparam int W         = 4 * DIGITS,
    localparam int LANES     = DIGITS / 2,
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          key,
    input  logic [7:0]          sw,
    output logic [W-1:0]        value,
    output logic [LW-1:0]       lane,
    output logic [7*DIGITS-1:0] hex
);

    // Wide enough to hold DEB_CYCLES-1, which is the count that ends a debounce.
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LaneLast = LW'(LANES - 1);

    // Key bit positions.
    localparam int KeyClr = 0;
    localparam int KeyLd  = 1;
    localparam int KeyInc = 2;

    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         st_q, st_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         cmd_q, rise;
    logic [W-1:0]       value_q, value_d;
    logic [LW-1:0]      lane_q, lane_d;

    // Two-flop synchronisers for the asynchronous key levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level change is accepted after DEB_CYCLES consecutive differing samples.
    // Any sample equal to the stable level clears the count, so bounces restart it.
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        rise  = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] != st_q[k]) begin
                if (cnt_q[k] == CntLast) begin
                    st_d[k] = sync2_q[k];
                    rise[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Debounce state and registered command pulses; cmd fires on the edge st rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= '0;
            cnt_q <= '0;
            cmd_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            cmd_q <= rise;
        end
    end

    // Command execution, one per cycle; lower-priority pulses in the same cycle are dropped.
    always_comb begin
        value_d = value_q;
        lane_d  = lane_q;
        if (cmd_q[KeyClr]) begin
            value_d = '0;
            lane_d  = '0;
        end else if (cmd_q[KeyLd]) begin
            value_d[8*int'(lane_q) +: 8] = sw;
            lane_d = (lane_q == LaneLast) ? '0 : lane_q + 1'b1;
        end else if (cmd_q[KeyInc]) begin
            value_d = value_q + 1'b1;
        end
    end

    // Register contents and load lane pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            lane_q  <= '0;
        end else begin
            value_q <= value_d;
            lane_q  <= lane_d;
        end
    end

    assign value = value_q;
    assign lane  = lane_q;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Segment decode straight from the register, no extra pipeline stage.
    always_comb begin
        hex = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex[7*i +: 7] = seg7(value_q[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_dio_bank.sv
// Scoreboard bench for dio_bank with DIGITS=4, DEB_CYCLES=4.
// Stimulus pushes the expected register state and the edge it must appear on;
// the monitor pops an entry whenever value or lane changes and compares it.
module tb_dio_bank;

    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int LAT    = DEB + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  key = '0;
    logic [7:0]  sw  = '0;
    logic [15:0] value;
    logic [0:0]  lane;
    logic [27:0] hex;

    typedef struct {
        int          cyc;   // -1: any edge
        logic [15:0] val;
        logic [0:0]  ln;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_on = 1'b0;

    dio_bank #(
        .DIGITS     (DIGITS),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .sw    (sw),
        .value (value),
        .lane  (lane),
        .hex   (hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Segment table written out independently for expected hex values.
    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16];
        t[0]  = 7'b1000000; t[1]  = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
        t[4]  = 7'b0011001; t[5]  = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
        t[8]  = 7'b0000000; t[9]  = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
        t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
        return t[n];
    endfunction

    function automatic logic [27:0] hex_of(input logic [15:0] v);
        return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [15:0] v, input logic [0:0] l);
        exp_t e;
        e.cyc = c;
        e.val = v;
        e.ln  = l;
        sb.push_back(e);
    endtask

    // Raise the given keys for hold edges, then release and let the release debounce.
    task automatic press(input logic [2:0] k, input logic [7:0] s, input int hold,
                         input bit expect_change, input logic [15:0] v, input logic [0:0] l);
        @(posedge clk);
        #1;
        sw  = s;
        key = k;
        if (expect_change) push(cyc + LAT, v, l);
        repeat (hold) @(posedge clk);
        #1;
        key = '0;
        sw  = 8'h00;
        repeat (12) @(posedge clk);
    endtask

    // Monitor: every observed change of value/lane must match the next scoreboard entry.
    initial begin
        logic [15:0] pv;
        logic [0:0]  pl;
        exp_t        e;
        wait (mon_on);
        pv = value;
        pl = lane;
        forever begin
            @(negedge clk);
            if (value !== pv || lane !== pl) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change value=%h lane=%0d at edge %0d, none expected",
                             value, lane, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc >= 0) chk("edge", 64'(cyc), 64'(e.cyc));
                    chk("value", 64'(value), 64'(e.val));
                    chk("lane", 64'(lane), 64'(e.ln));
                    chk("hex", 64'(hex), 64'(hex_of(e.val)));
                end
                pv = value;
                pl = lane;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // Reset state and idle with keys low.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_value", 64'(value), 64'h0);
        chk("rst_lane", 64'(lane), 64'h0);
        chk("rst_hex", 64'(hex), 64'({4{7'b1000000}}));

        // Held load: exactly one load, 7 edges after E1.
        press(3'b010, 8'hA5, 30, 1'b1, 16'h00A5, 1'b1);
        chk("held_load_value", 64'(value), 64'h00A5);

        // Clear, then two loads wrapping the lane.
        press(3'b001, 8'h00, 10, 1'b1, 16'h0000, 1'b0);
        press(3'b010, 8'h3C, 10, 1'b1, 16'h003C, 1'b1);
        press(3'b010, 8'h12, 10, 1'b1, 16'h123C, 1'b0);
        chk("hex_123c", 64'(hex), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b1000110}));

        // Clear and load rising together: clear wins, the load is dropped.
        press(3'b011, 8'h77, 10, 1'b1, 16'h0000, 1'b0);
        chk("clr_ld_lane", 64'(lane), 64'h0);

        // Build 0xFFFF with lane 1, then increment wraps to 0 keeping the lane.
        press(3'b010, 8'hFF, 10, 1'b1, 16'h00FF, 1'b1);
        press(3'b010, 8'hFF, 10, 1'b1, 16'hFFFF, 1'b0);
        press(3'b010, 8'hFF, 10, 1'b1, 16'hFFFF, 1'b1);
        press(3'b100, 8'h00, 10, 1'b1, 16'h0000, 1'b1);

        // Three-sample glitch on the increment key: no command.
        press(3'b100, 8'h00, 3, 1'b0, 16'h0000, 1'b0);
        chk("glitch_value", 64'(value), 64'h0000);
        press(3'b100, 8'h00, 10, 1'b1, 16'h0001, 1'b1);

        // Reset mid-debounce with the load key held; it debounces afresh after release.
        @(posedge clk);
        #1;
        sw  = 8'h5A;
        key = 3'b010;
        repeat (4) @(posedge clk);
        #1;
        push(-1, 16'h0000, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc + LAT, 16'h005A, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        key = '0;
        repeat (12) @(posedge clk);

        // Drain the scoreboard within a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
